// File: rtl/mcu_link_pkg.sv
// Shared definitions for the MCU link: RX FSM state encodings, MCU byte codes
// and the default bit timing for the 122.88 MHz main clock at 19200 baud.
package mcu_link_pkg;

    localparam logic [2:0] RX_IDLE      = 3'd0;
    localparam logic [2:0] RX_START     = 3'd1;
    localparam logic [2:0] RX_DATA      = 3'd2;
    localparam logic [2:0] RX_STOP      = 3'd3;
    localparam logic [2:0] RX_WAIT_HIGH = 3'd4;
    localparam logic [2:0] RX_CLEANUP   = 3'd5;

    localparam logic [7:0] MCU_CODE_RADIO = 8'h23;
    localparam logic [7:0] MCU_CODE_PTT   = 8'h24;

    localparam int RX_CLKS_PER_BIT_DEFAULT = 6400;

endpackage

// File: rtl/mcu_rx_fifo.sv
// Small synchronous byte FIFO for the MCU RX path; head is shown combinationally.
// Pointers carry one extra MSB so full and empty can be told apart.
module mcu_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is only legal when the head is retired that same cycle.
    assign push_ok  = push_i & (~full_o | pop_i);
    assign pop_ok   = pop_i & ~empty_o;
    assign wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/mcu_uart_rx.sv
// 8N1 UART receiver for MCU-to-FPGA bytes with valid/ack handshake and sticky errors.
// Define MCU_RX_FIFO_EN to queue bytes in mcu_rx_fifo instead of a single holding register.
module mcu_uart_rx
    import mcu_link_pkg::*;
#(
    parameter int CLKS_PER_BIT = RX_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_Serial,
    input  logic       i_RX_Ack,
    input  logic       i_Clear_Err,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Valid,
    output logic       o_RX_Active,
    output logic       o_Frame_Err,
    output logic       o_Overrun
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q, rx_sync_q;
    logic [1:0]       primed_q;
    logic             armed_q, armed_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             active_q, active_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             commit, frame_evt, overrun_evt, ack_eff;

    // Starts are only accepted once the real line has been seen high after reset,
    // so a line that is still low when reset releases cannot fake a start bit.
    assign armed_d = armed_q | (primed_q[1] & rx_sync_q);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        active_d  = active_q;
        commit    = 1'b0;
        frame_evt = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (armed_q && !rx_sync_q) begin
                    state_d   = RX_START;
                    clk_cnt_d = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    if (!rx_sync_q) begin
                        state_d  = RX_DATA;
                        active_d = 1'b1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == BIT_LAST) begin
                    clk_cnt_d = '0;
                    active_d  = 1'b0;
                    if (rx_sync_q) begin
                        commit  = 1'b1;
                        state_d = RX_CLEANUP;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = RX_WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) begin
                    state_d = RX_IDLE;
                end
            end
            RX_CLEANUP: state_d = RX_IDLE;
            default:    state_d = RX_IDLE;
        endcase
    end

    assign ack_eff = i_RX_Ack & o_RX_Valid;

`ifdef MCU_RX_FIFO_EN
    logic       fifo_push, fifo_empty, fifo_full;
    logic [7:0] fifo_head;

    assign fifo_push   = commit & (~fifo_full | ack_eff);
    assign overrun_evt = commit & fifo_full & ~ack_eff;

    mcu_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i   (i_Clock),
        .rst_ni  (i_Rst_L),
        .push_i  (fifo_push),
        .pop_i   (ack_eff),
        .data_i  (shift_q),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign o_RX_Byte  = fifo_head;
    assign o_RX_Valid = ~fifo_empty;
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;

    // A commit that coincides with an ack replaces the held byte instead of overrunning.
    always_comb begin
        hold_d      = hold_q;
        valid_d     = valid_q;
        overrun_evt = 1'b0;
        if (commit) begin
            if (!valid_q || ack_eff) begin
                hold_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_evt = 1'b1;
            end
        end else if (ack_eff) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    assign o_RX_Byte  = hold_q;
    assign o_RX_Valid = valid_q;
`endif

    assign frame_err_d = frame_evt   | (frame_err_q & ~i_Clear_Err);
    assign overrun_d   = overrun_evt | (overrun_q & ~i_Clear_Err);

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            primed_q    <= '0;
            armed_q     <= 1'b0;
            state_q     <= RX_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            active_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= i_RX_Serial;
            rx_sync_q   <= rx_meta_q;
            primed_q    <= {primed_q[0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            active_q    <= active_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_RX_Active = active_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Overrun   = overrun_q;

endmodule
